// File: rtl/lieat_clint.sv
// lieat_clint: core-local interruptor holding the machine timer (mtime/mtimecmp)
// and the machine software-interrupt bit (msip). A single-outstanding
// valid/ready slave port gives word access to the 64-bit registers as lo/hi
// halves. The interrupt levels feed the commit-stage CSR unit, which masks them.
module lieat_clint #(
  parameter int XLEN     = 32,
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clint_req_valid,
  output logic              clint_req_ready,
  input  logic              clint_req_write,
  input  logic [ADDR_W-1:0] clint_req_addr,
  input  logic [XLEN-1:0]   clint_req_wdata,
  output logic              clint_rsp_valid,
  input  logic              clint_rsp_ready,
  output logic [XLEN-1:0]   clint_rsp_rdata,
  output logic              clint_rsp_err,
  output logic              time_interrupt,
  output logic              msip_interrupt,
  output logic [63:0]       mtime_o
);

  // Register offsets (byte addresses; the two low bits are never decoded).
  localparam logic [ADDR_W-1:0] OFF_MSIP    = ADDR_W'(32'h0000_0000);
  localparam logic [ADDR_W-1:0] OFF_CMP_LO  = ADDR_W'(32'h0000_4000);
  localparam logic [ADDR_W-1:0] OFF_CMP_HI  = ADDR_W'(32'h0000_4004);
  localparam logic [ADDR_W-1:0] OFF_TIME_LO = ADDR_W'(32'h0000_BFF8);
  localparam logic [ADDR_W-1:0] OFF_TIME_HI = ADDR_W'(32'h0000_BFFC);

  // Last prescaler count; the counter is 16 bits wide to cover TICK_DIV up to 65535.
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_MSIP    = 3'd1,
    SEL_CMP_LO  = 3'd2,
    SEL_CMP_HI  = 3'd3,
    SEL_TIME_LO = 3'd4,
    SEL_TIME_HI = 3'd5
  } sel_e;

  // Map a byte offset onto the register it selects (word granularity).
  function automatic sel_e decode_offset(input logic [ADDR_W-1:0] addr);
    sel_e sel;
    if (addr[ADDR_W-1:2] == OFF_MSIP[ADDR_W-1:2]) begin
      sel = SEL_MSIP;
    end else if (addr[ADDR_W-1:2] == OFF_CMP_LO[ADDR_W-1:2]) begin
      sel = SEL_CMP_LO;
    end else if (addr[ADDR_W-1:2] == OFF_CMP_HI[ADDR_W-1:2]) begin
      sel = SEL_CMP_HI;
    end else if (addr[ADDR_W-1:2] == OFF_TIME_LO[ADDR_W-1:2]) begin
      sel = SEL_TIME_LO;
    end else if (addr[ADDR_W-1:2] == OFF_TIME_HI[ADDR_W-1:2]) begin
      sel = SEL_TIME_HI;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

  // State flops
  logic [15:0]     cnt_q,        cnt_d;
  logic [63:0]     mtime_q,      mtime_d;
  logic [63:0]     mtimecmp_q,   mtimecmp_d;
  logic            msip_q,       msip_d;
  logic            time_int_q,   time_int_d;
  logic            rsp_valid_q,  rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q,  rsp_rdata_d;
  logic            rsp_err_q,    rsp_err_d;

  // Combinational helpers
  logic            tick;
  logic            req_ready;
  logic            accept;
  logic            wr_en;
  sel_e            sel;
  logic [31:0]     wr_word;
  logic [63:0]     mtime_inc;
  logic [31:0]     rd_word;
  logic            rd_err;
  logic            unused_addr_bits;

  assign wr_word          = clint_req_wdata[31:0];
  assign unused_addr_bits = ^clint_req_addr[1:0];

  // Prescaler: count 0..TICK_DIV-1 and raise tick on the last count, then wrap.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (cnt_q == TICK_LAST) begin
      tick  = 1'b1;
      cnt_d = 16'h0000;
    end else begin
      tick  = 1'b0;
      cnt_d = cnt_q + 16'h0001;
    end
  end

  // Handshake: a new request may enter whenever the response slot is free or draining.
  always_comb begin
    req_ready = ~rsp_valid_q | clint_rsp_ready;
    accept    = clint_req_valid & req_ready;
    wr_en     = accept & clint_req_write;
    sel       = decode_offset(clint_req_addr);
  end

  // Register next state: timer increment first, then a bus write overrides only its own half.
  always_comb begin
    if (tick) begin
      mtime_inc = mtime_q + 64'd1;
    end else begin
      mtime_inc = mtime_q;
    end
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en) begin
      case (sel)
        SEL_MSIP:    msip_d            = wr_word[0];
        SEL_CMP_LO:  mtimecmp_d[31:0]  = wr_word;
        SEL_CMP_HI:  mtimecmp_d[63:32] = wr_word;
        SEL_TIME_LO: mtime_d[31:0]     = wr_word;
        SEL_TIME_HI: mtime_d[63:32]    = wr_word;
        default:     msip_d            = msip_q;
      endcase
    end else begin
      msip_d = msip_q;
    end
  end

  // Read mux over the pre-update register values; unmapped offsets flag an error.
  always_comb begin
    rd_word = 32'h0000_0000;
    rd_err  = 1'b0;
    case (sel)
      SEL_MSIP:    rd_word = {31'h0000_0000, msip_q};
      SEL_CMP_LO:  rd_word = mtimecmp_q[31:0];
      SEL_CMP_HI:  rd_word = mtimecmp_q[63:32];
      SEL_TIME_LO: rd_word = mtime_q[31:0];
      SEL_TIME_HI: rd_word = mtime_q[63:32];
      default: begin
        rd_word = 32'h0000_0000;
        rd_err  = 1'b1;
      end
    endcase
  end

  // Response slot: load on accept, clear when consumed, otherwise hold stable.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = rd_err;
      if (clint_req_write) begin
        rsp_rdata_d = {XLEN{1'b0}};
      end else begin
        rsp_rdata_d = XLEN'(rd_word);
      end
    end else if (clint_rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_rdata_d = {XLEN{1'b0}};
      rsp_err_d   = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Timer compare on next-state values so the level matches the registers of the same cycle.
  always_comb begin
    if (mtime_d >= mtimecmp_d) begin
      time_int_d = 1'b1;
    end else begin
      time_int_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset also drops any pending response.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= 16'h0000;
      mtime_q     <= 64'h0000_0000_0000_0000;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      time_int_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {XLEN{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      time_int_q  <= time_int_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign clint_req_ready = req_ready;
  assign clint_rsp_valid = rsp_valid_q;
  assign clint_rsp_rdata = rsp_rdata_q;
  assign clint_rsp_err   = rsp_err_q;
  assign time_interrupt  = time_int_q;
  assign msip_interrupt  = msip_q;
  assign mtime_o         = mtime_q;

endmodule
